// File: rtl/param_fifo.sv
// param_fifo: parametrised synchronous FIFO with standard/FWFT read modes,
// occupancy count, almost flags, synchronous flush and sticky error flags.
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_params
    $error("param_fifo: illegal DEPTH or threshold parameters");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  do_wr, do_rd;

  assign full         = count_q == CW'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AF_THRESH);
  assign almost_empty = count_q <= CW'(AE_THRESH);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign o_data       = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr_q]) : rdata_q;

  // clr masks both requests so they neither move state nor raise sticky flags
  always_comb begin
    do_wr       = wren && !full && !clr;
    do_rd       = rden && !empty && !clr;
    wr_ptr_d    = clr ? '0 : !do_wr ? wr_ptr_q : (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d    = clr ? '0 : !do_rd ? rd_ptr_q : (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    count_d     = clr ? '0 : count_q + CW'(do_wr) - CW'(do_rd);
    rdata_d     = do_rd ? mem_q[rd_ptr_q] : rdata_q;
    overflow_d  = !clr && (overflow_q || (wren && full));
    underflow_d = !clr && (underflow_q || (rden && empty));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= i_data;
  end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed checks of param_fifo in standard (DEPTH 8 and 6)
// and FWFT (DEPTH 8) configurations.
module tb_param_fifo;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic       a_clr, a_wr, a_rd, a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [7:0] a_di, a_do;
  logic [3:0] a_cnt;
  logic       b_clr, b_wr, b_rd, b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [7:0] b_di, b_do;
  logic [2:0] b_cnt;
  logic       c_clr, c_wr, c_rd, c_full, c_empty, c_af, c_ae, c_ov, c_un;
  logic [7:0] c_di, c_do;
  logic [3:0] c_cnt;

  param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .wren(a_wr), .i_data(a_di), .rden(a_rd),
    .o_data(a_do), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_cnt), .overflow(a_ov), .underflow(a_un));

  param_fifo #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(0)) u_odd (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .wren(b_wr), .i_data(b_di), .rden(b_rd),
    .o_data(b_do), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_cnt), .overflow(b_ov), .underflow(b_un));

  param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .wren(c_wr), .i_data(c_di), .rden(c_rd),
    .o_data(c_do), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .count(c_cnt), .overflow(c_ov), .underflow(c_un));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_clr, a_wr, a_rd, b_clr, b_wr, b_rd, c_clr, c_wr, c_rd} = '0;
    a_di = '0; b_di = '0; c_di = '0;
    #2;
    check("rst_empty", 32'(a_empty), 1);
    check("rst_full", 32'(a_full), 0);
    check("rst_cnt", 32'(a_cnt), 0);
    check("rst_ae", 32'(a_ae), 1);
    check("rst_af", 32'(a_af), 0);
    check("rst_odata", 32'(a_do), 0);
    check("rst_ov", 32'(a_ov), 0);
    check("rst_un", 32'(a_un), 0);
    check("rst_fwft_odata", 32'(c_do), 0);
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1; a_di = 8'((i + 1) * 10);
      tick;
      check("fill_cnt", 32'(a_cnt), i + 1);
      check("fill_af", 32'(a_af), (i >= 6) ? 1 : 0);
    end
    a_wr = 1'b0;
    check("fill_full", 32'(a_full), 1);
    for (int i = 0; i < 8; i++) begin
      a_rd = 1'b1;
      tick;
      check("drain_data", 32'(a_do), (i + 1) * 10);
    end
    a_rd = 1'b0;
    check("drain_empty", 32'(a_empty), 1);
    check("drain_cnt", 32'(a_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      a_wr = 1'b1; a_di = 8'(i + 1);
      tick;
    end
    for (int i = 0; i < 5; i++) begin
      a_wr = 1'b1; a_rd = 1'b1; a_di = 8'(i + 4);
      tick;
      check("sim_cnt", 32'(a_cnt), 3);
      check("sim_data", 32'(a_do), i + 1);
    end
    a_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_di = 8'(i + 9);
      tick;
    end
    a_wr = 1'b0;
    check("refill_full", 32'(a_full), 1);
    a_wr = 1'b1; a_rd = 1'b1; a_di = 8'd99;
    tick;
    a_wr = 1'b0; a_rd = 1'b0;
    check("full_rw_cnt", 32'(a_cnt), 7);
    check("full_rw_ov", 32'(a_ov), 1);
    check("full_rw_data", 32'(a_do), 6);
    tick;
    check("ov_sticky", 32'(a_ov), 1);
    a_clr = 1'b1; a_wr = 1'b1; a_di = 8'd77;
    tick;
    a_clr = 1'b0; a_wr = 1'b0;
    check("clr_cnt", 32'(a_cnt), 0);
    check("clr_empty", 32'(a_empty), 1);
    check("clr_ov", 32'(a_ov), 0);
    check("clr_hold_data", 32'(a_do), 6);
    a_wr = 1'b1; a_rd = 1'b1; a_di = 8'h55;
    tick;
    a_wr = 1'b0; a_rd = 1'b0;
    check("empty_rw_cnt", 32'(a_cnt), 1);
    check("empty_rw_un", 32'(a_un), 1);
    check("empty_rw_hold", 32'(a_do), 6);
    a_rd = 1'b1;
    tick;
    check("pop_55", 32'(a_do), 32'h55);
    tick;
    a_rd = 1'b0;
    check("un_sticky", 32'(a_un), 1);
    check("rej_rd_hold", 32'(a_do), 32'h55);
    a_clr = 1'b1; a_wr = 1'b1; a_di = 8'h66;
    tick;
    a_clr = 1'b0; a_wr = 1'b0;
    check("clr2_cnt", 32'(a_cnt), 0);
    check("clr2_un", 32'(a_un), 0);
    check("clr2_ov", 32'(a_ov), 0);
    check("clr2_empty", 32'(a_empty), 1);
    for (int i = 0; i < 6; i++) begin
      b_wr = 1'b1; b_di = 8'(i + 1);
      tick;
    end
    b_wr = 1'b0;
    check("odd_full1", 32'(b_full), 1);
    for (int i = 0; i < 4; i++) begin
      b_rd = 1'b1;
      tick;
      check("odd_rd1", 32'(b_do), i + 1);
    end
    b_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_wr = 1'b1; b_di = 8'(i + 7);
      tick;
    end
    b_wr = 1'b0;
    check("odd_full2", 32'(b_full), 1);
    check("odd_cnt", 32'(b_cnt), 6);
    for (int i = 0; i < 6; i++) begin
      b_rd = 1'b1;
      tick;
      check("odd_rd2", 32'(b_do), i + 5);
    end
    b_rd = 1'b0;
    check("odd_empty", 32'(b_empty), 1);
    c_wr = 1'b1; c_di = 8'hA5;
    tick;
    c_wr = 1'b0;
    check("fwft_show", 32'(c_do), 32'hA5);
    check("fwft_cnt", 32'(c_cnt), 1);
    tick;
    check("fwft_hold", 32'(c_do), 32'hA5);
    c_rd = 1'b1;
    tick;
    c_rd = 1'b0;
    check("fwft_pop_zero", 32'(c_do), 0);
    check("fwft_empty", 32'(c_empty), 1);
    c_wr = 1'b1; c_di = 8'h11;
    tick;
    c_di = 8'h22;
    tick;
    c_wr = 1'b0;
    check("fwft_head", 32'(c_do), 32'h11);
    c_rd = 1'b1;
    tick;
    check("fwft_next", 32'(c_do), 32'h22);
    tick;
    c_rd = 1'b0;
    check("fwft_drained", 32'(c_do), 0);
    for (int i = 0; i < 5; i++) begin
      a_wr = 1'b1; a_di = 8'((i + 1) * 3);
      tick;
    end
    a_wr = 1'b0;
    check("pre_rst_cnt", 32'(a_cnt), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", 32'(a_cnt), 0);
    check("arst_empty", 32'(a_empty), 1);
    check("arst_full", 32'(a_full), 0);
    check("arst_ae", 32'(a_ae), 1);
    check("arst_odata", 32'(a_do), 0);
    #1;
    rst_n = 1'b1;
    a_wr = 1'b1; a_di = 8'hC1;
    tick;
    a_di = 8'hC2;
    tick;
    a_wr = 1'b0;
    check("post_rst_cnt", 32'(a_cnt), 2);
    a_rd = 1'b1;
    tick;
    check("post_rst_rd1", 32'(a_do), 32'hC1);
    tick;
    a_rd = 1'b0;
    check("post_rst_rd2", 32'(a_do), 32'hC2);
    check("post_rst_empty", 32'(a_empty), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
